// File: rtl/alu_iter.sv
// Multi-cycle ALU for the 8088-class core: single-cycle ADD..CMP/PASS, bit-serial
// shifts/rotates, shift-add MUL and restoring DIV over byte (WIDTH/2) or word operands.
module alu_iter #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             size,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [CNT_W-1:0] cnt,
  input  logic [11:0]      flags_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [11:0]      flags_out,
  output logic             div_err
);
  localparam int H  = WIDTH / 2;
  localparam int NW = $clog2(WIDTH + 1);
  localparam int SW = (CNT_W > NW) ? CNT_W : NW;

  localparam logic [3:0] OP_ADD = 4'd0,  OP_OR  = 4'd1,  OP_ADC = 4'd2,  OP_SBB = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4,  OP_SUB = 4'd5,  OP_XOR = 4'd6,  OP_CMP = 4'd7;
  localparam logic [3:0] OP_ROL = 4'd8,  OP_ROR = 4'd9,  OP_SHL = 4'd10, OP_SHR = 4'd11;
  localparam logic [3:0] OP_SAR = 4'd12, OP_MUL = 4'd13, OP_DIV = 4'd14, OP_PASS = 4'd15;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;

  function automatic logic [WIDTH-1:0] fmask(input logic sz);
    return sz ? {WIDTH{1'b1}} : {{H{1'b0}}, {H{1'b1}}};
  endfunction

  function automatic logic [WIDTH-1:0] ftop(input logic sz);
    logic [WIDTH-1:0] t;
    t = '0;
    if (sz) t[WIDTH-1] = 1'b1;
    else    t[H-1]     = 1'b1;
    return t;
  endfunction

  function automatic logic fmsb(input logic [WIDTH-1:0] x, input logic sz);
    return sz ? x[WIDTH-1] : x[H-1];
  endfunction

  function automatic logic fmsb2(input logic [WIDTH-1:0] x, input logic sz);
    return sz ? x[WIDTH-2] : x[H-2];
  endfunction

  // Architecturally fixed flag bits: bit1 reads 1, bits 3 and 5 read 0.
  function automatic logic [11:0] ffix(input logic [11:0] f);
    logic [11:0] g;
    g    = f;
    g[1] = 1'b1;
    g[3] = 1'b0;
    g[5] = 1'b0;
    return g;
  endfunction

  function automatic logic [11:0] fszp(input logic [11:0] f, input logic [WIDTH-1:0] r,
                                       input logic sz);
    logic [11:0] g;
    g    = f;
    g[7] = fmsb(r, sz);
    g[6] = (r == '0);
    g[2] = ~^r[7:0];
    return g;
  endfunction

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic             size_q, size_d, amsb_q, amsb_d;
  logic [11:0]      fin_q, fin_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] w_q, w_d, h_q, h_d, d_q, d_d;
  logic [WIDTH-1:0] result_q, result_d, result_hi_q, result_hi_d;
  logic [11:0]      flags_q, flags_d;
  logic             div_err_q, div_err_d;

  // Single-cycle ALU path, evaluated straight from the request inputs.
  logic [WIDTH-1:0] am, bm, alu_res;
  logic [WIDTH:0]   alu_sum;
  logic [11:0]      alu_flg;
  logic             alu_sub, alu_log, alu_c, alu_a, alu_o;

  always_comb begin
    am      = a & fmask(size);
    bm      = b & fmask(size);
    alu_sub = (op == OP_SBB) || (op == OP_SUB) || (op == OP_CMP);
    alu_log = (op == OP_OR) || (op == OP_AND) || (op == OP_XOR);
    case (op)
      OP_ADD:         alu_sum = {1'b0, am} + {1'b0, bm};
      OP_ADC:         alu_sum = {1'b0, am} + {1'b0, bm} + {{WIDTH{1'b0}}, flags_in[0]};
      OP_SBB:         alu_sum = {1'b0, am} - {1'b0, bm} - {{WIDTH{1'b0}}, flags_in[0]};
      OP_SUB, OP_CMP: alu_sum = {1'b0, am} - {1'b0, bm};
      OP_OR:          alu_sum = {1'b0, am | bm};
      OP_AND:         alu_sum = {1'b0, am & bm};
      OP_XOR:         alu_sum = {1'b0, am ^ bm};
      default:        alu_sum = {1'b0, am};
    endcase
    alu_res = alu_sum[WIDTH-1:0] & fmask(size);
    alu_c   = size ? alu_sum[WIDTH] : alu_sum[H];
    alu_a   = am[4] ^ bm[4] ^ alu_res[4];
    if (alu_sub)
      alu_o = (fmsb(am, size) != fmsb(bm, size)) && (fmsb(alu_res, size) != fmsb(am, size));
    else
      alu_o = (fmsb(am, size) == fmsb(bm, size)) && (fmsb(alu_res, size) != fmsb(am, size));
    alu_flg     = fszp(ffix(flags_in), alu_res, size);
    alu_flg[11] = alu_log ? 1'b0 : alu_o;
    alu_flg[4]  = alu_log ? 1'b0 : alu_a;
    alu_flg[0]  = alu_log ? 1'b0 : alu_c;
    if (op == OP_PASS) alu_flg = ffix(flags_in);
  end

  // One iteration of the serial ops on the working registers, plus final flags.
  logic [WIDTH-1:0] st_w, st_h, st_top;
  logic [WIDTH:0]   st_sum, st_r;
  logic             st_c, st_msb;
  logic [11:0]      fin_flg;

  always_comb begin
    st_w   = w_q;
    st_h   = h_q;
    st_c   = 1'b0;
    st_sum = '0;
    st_r   = '0;
    st_top = ftop(size_q);
    st_msb = fmsb(w_q, size_q);
    case (op_q)
      OP_ROL: begin st_c = st_msb; st_w = ((w_q << 1) & fmask(size_q)) | {{(WIDTH-1){1'b0}}, st_msb}; end
      OP_ROR: begin st_c = w_q[0]; st_w = (w_q >> 1) | (w_q[0] ? st_top : '0); end
      OP_SHL: begin st_c = st_msb; st_w = (w_q << 1) & fmask(size_q); end
      OP_SHR: begin st_c = w_q[0]; st_w = w_q >> 1; end
      OP_SAR: begin st_c = w_q[0]; st_w = (w_q >> 1) | (st_msb ? st_top : '0); end
      OP_MUL: begin
        st_sum = {1'b0, h_q} + (w_q[0] ? {1'b0, d_q} : '0);
        st_h   = st_sum[WIDTH:1];
        st_w   = (w_q >> 1) | (st_sum[0] ? st_top : '0);
      end
      OP_DIV: begin
        st_r = {h_q, st_msb};
        st_w = (w_q << 1) & fmask(size_q);
        if (st_r >= {1'b0, d_q}) begin
          st_r    = st_r - {1'b0, d_q};
          st_w[0] = 1'b1;
        end
        st_h = st_r[WIDTH-1:0];
      end
      default: ;
    endcase

    fin_flg = ffix(fin_q);
    case (op_q)
      OP_ROL: begin fin_flg[0] = st_c; fin_flg[11] = fmsb(st_w, size_q) ^ st_c; end
      OP_ROR: begin fin_flg[0] = st_c; fin_flg[11] = fmsb(st_w, size_q) ^ fmsb2(st_w, size_q); end
      OP_SHL, OP_SHR, OP_SAR: begin
        fin_flg     = fszp(fin_flg, st_w, size_q);
        fin_flg[4]  = 1'b0;
        fin_flg[0]  = st_c;
        fin_flg[11] = (op_q == OP_SHL) ? (fmsb(st_w, size_q) ^ st_c) :
                      (op_q == OP_SHR) ? amsb_q : 1'b0;
      end
      OP_MUL: begin
        fin_flg     = fszp(fin_flg, st_w, size_q);
        fin_flg[4]  = 1'b0;
        fin_flg[0]  = (st_h != '0);
        fin_flg[11] = (st_h != '0);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    size_d      = size_q;
    fin_d       = fin_q;
    amsb_d      = amsb_q;
    cnt_d       = cnt_q;
    w_d         = w_q;
    h_d         = h_q;
    d_d         = d_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    flags_d     = flags_q;
    div_err_d   = div_err_q;
    case (state_q)
      IDLE: if (start) begin
        op_d      = op;
        size_d    = size;
        fin_d     = flags_in;
        amsb_d    = fmsb(am, size);
        div_err_d = 1'b0;
        state_d   = FIN;
        if (op <= OP_CMP || op == OP_PASS) begin
          flags_d = alu_flg;
          if (op != OP_CMP) begin result_d = alu_res; result_hi_d = '0; end
        end else if (op <= OP_SAR) begin
          if (cnt == '0) begin
            result_d = am; result_hi_d = '0; flags_d = ffix(flags_in);
          end else begin
            w_d = am; cnt_d = SW'(cnt); state_d = RUN;
          end
        end else if (op == OP_MUL) begin
          w_d = bm; h_d = '0; d_d = am; state_d = RUN;
          cnt_d = size ? SW'(WIDTH) : SW'(H);
        end else if (bm == '0) begin
          // Divide by zero finishes at once and leaves the result registers untouched.
          div_err_d = 1'b1;
          flags_d   = ffix(flags_in);
        end else begin
          w_d = am; h_d = '0; d_d = bm; state_d = RUN;
          cnt_d = size ? SW'(WIDTH) : SW'(H);
        end
      end
      RUN: begin
        w_d   = st_w;
        h_d   = st_h;
        cnt_d = cnt_q - SW'(1);
        if (cnt_q == SW'(1)) begin
          state_d     = FIN;
          result_d    = st_w;
          result_hi_d = (op_q == OP_MUL || op_q == OP_DIV) ? st_h : '0;
          flags_d     = fin_flg;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      size_q      <= 1'b0;
      fin_q       <= '0;
      amsb_q      <= 1'b0;
      cnt_q       <= '0;
      w_q         <= '0;
      h_q         <= '0;
      d_q         <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= 12'h002;
      div_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      size_q      <= size_d;
      fin_q       <= fin_d;
      amsb_q      <= amsb_d;
      cnt_q       <= cnt_d;
      w_q         <= w_d;
      h_q         <= h_d;
      d_q         <= d_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      flags_q     <= flags_d;
      div_err_q   <= div_err_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign flags_out = flags_q;
  assign div_err   = div_err_q;
endmodule
